uart_tx_arbiter: RTL and testbench



---
 rtl/uart_tx_arbiter.sv | 145 ++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Packet-level round-robin arbiter sharing one uart_tx byte transmitter among NUM_REQ requesters.
// The owner keeps the transmitter until it sends a last-flagged byte or idles for LOCK_TIMEOUT cycles.
module uart_tx_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int LOCK_TIMEOUT = 1023,
   localparam int IDW         = $clog2(NUM_REQ)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NUM_REQ-1:0]   req_valid,
   input  logic [NUM_REQ-1:0]   req_last,
   input  logic [8*NUM_REQ-1:0] req_data,
   output logic [NUM_REQ-1:0]   req_ready,
   output logic [7:0]           tx_data,
   output logic                 tx_valid,
   input  logic                 tx_busy,
   output logic                 grant_valid,
   output logic [IDW-1:0]       grant_id,
   output logic                 timeout_pulse
);

   localparam int CW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, LOCKED, ISSUE, WAIT} state_t;

   state_t         r_state, w_stateNext;
   logic [7:0]     r_txData, w_txDataNext, w_ownerData;
   logic           r_txValid, w_txValidNext;
   logic           r_grantValid, w_grantValidNext;
   logic [IDW-1:0] r_grantId, w_grantIdNext, w_rrPick;
   logic           r_timeoutPulse, w_timeoutNext;
   logic           r_lastQ, w_lastNext;
   logic [CW-1:0]  r_idleCnt, w_idleCntNext, w_idleInc;
   logic           w_rrFound, w_ownerValid, w_fire, w_timeoutHit;

   // Search starts just after the previous owner so every requester gets a turn.
   always_comb begin
      int idx;
      w_rrPick  = r_grantId;
      w_rrFound = 1'b0;
      for (int k = 1; k <= NUM_REQ; k++) begin
         idx = (int'(r_grantId) + k) % NUM_REQ;
         if (!w_rrFound && req_valid[IDW'(idx)]) begin
            w_rrFound = 1'b1;
            w_rrPick  = IDW'(idx);
         end
      end
   end

   always_comb begin
      w_ownerData = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (r_grantId == IDW'(i)) w_ownerData = req_data[8*i +: 8];
      end
   end

   always_comb begin
      req_ready = '0;
      if (r_state == LOCKED && !tx_busy) req_ready[r_grantId] = 1'b1;
   end

   assign w_ownerValid = req_valid[r_grantId];
   assign w_fire       = (r_state == LOCKED) && !tx_busy && w_ownerValid;
   assign w_idleInc    = (r_idleCnt == {CW{1'b1}}) ? r_idleCnt : r_idleCnt + 1'b1;
   assign w_timeoutHit = (LOCK_TIMEOUT != 0) && (w_idleInc >= CW'(LOCK_TIMEOUT));

   always_comb begin
      w_stateNext      = r_state;
      w_txDataNext     = r_txData;
      w_txValidNext    = 1'b0;
      w_grantValidNext = r_grantValid;
      w_grantIdNext    = r_grantId;
      w_timeoutNext    = 1'b0;
      w_lastNext       = r_lastQ;
      w_idleCntNext    = r_idleCnt;
      case (r_state)
         IDLE: begin
            w_idleCntNext = '0;
            if (w_rrFound) begin
               w_grantIdNext    = w_rrPick;
               w_grantValidNext = 1'b1;
               w_stateNext      = LOCKED;
            end
         end
         LOCKED: begin
            // A transfer takes precedence over an idle count that would expire this cycle.
            if (w_fire) begin
               w_txDataNext  = w_ownerData;
               w_lastNext    = req_last[r_grantId];
               w_txValidNext = 1'b1;
               w_idleCntNext = '0;
               w_stateNext   = ISSUE;
            end else if (!w_ownerValid) begin
               w_idleCntNext = w_idleInc;
               if (w_timeoutHit) begin
                  w_grantValidNext = 1'b0;
                  w_timeoutNext    = 1'b1;
                  w_stateNext      = IDLE;
               end
            end
         end
         ISSUE: w_stateNext = WAIT;
         WAIT: begin
            if (!tx_busy) begin
               if (r_lastQ) begin
                  w_grantValidNext = 1'b0;
                  w_stateNext      = IDLE;
               end else begin
                  w_stateNext = LOCKED;
               end
            end
         end
         default: w_stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state        <= IDLE;
         r_txData       <= '0;
         r_txValid      <= 1'b0;
         r_grantValid   <= 1'b0;
         r_grantId      <= IDW'(NUM_REQ - 1);
         r_timeoutPulse <= 1'b0;
         r_lastQ        <= 1'b0;
         r_idleCnt      <= '0;
      end else begin
         r_state        <= w_stateNext;
         r_txData       <= w_txDataNext;
         r_txValid      <= w_txValidNext;
         r_grantValid   <= w_grantValidNext;
         r_grantId      <= w_grantIdNext;
         r_timeoutPulse <= w_timeoutNext;
         r_lastQ        <= w_lastNext;
         r_idleCnt      <= w_idleCntNext;
      end
   end

   assign tx_data       = r_txData;
   assign tx_valid      = r_txValid;
   assign grant_valid   = r_grantValid;
   assign grant_id      = r_grantId;
   assign timeout_pulse = r_timeoutPulse;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: per-requester byte queues, a busy-timer uart_tx model,
// and a packet-level round-robin reference model that predicts the transmitted byte stream.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int LT    = 8;
   localparam int FRAME = 30;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [N-1:0]     req_valid = '0;
   logic [N-1:0]     req_last = '0;
   logic [8*N-1:0]   req_data = '0;
   logic [N-1:0]     req_ready;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_busy;
   logic             grant_valid;
   logic [1:0]       grant_id;
   logic             timeout_pulse;

   logic [8:0] mem [N][128];
   int         head [N];
   int         tail [N];
   logic [7:0] expData [256];
   int         expId [256];
   int         expN = 0;
   int         nTx = 0;
   int         readyViol = 0;
   int         cyc = 0;
   int         lastTxCyc = -1000;
   logic       prevTxValid = 1'b0;
   int         busyCnt = 0;
   int         testsRun = 0;
   int         failCount = 0;

   uart_tx_arbiter #(.NUM_REQ(N), .LOCK_TIMEOUT(LT)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_last(req_last), .req_data(req_data),
      .req_ready(req_ready), .tx_data(tx_data), .tx_valid(tx_valid), .tx_busy(tx_busy),
      .grant_valid(grant_valid), .grant_id(grant_id), .timeout_pulse(timeout_pulse)
   );

   always #5 clk = ~clk;

   // uart_tx stand-in: a loaded byte keeps tx_busy high for one frame; it ignores rst on purpose.
   always @(posedge clk) begin
      if (busyCnt > 0) busyCnt <= busyCnt - 1;
      else if (tx_valid) busyCnt <= FRAME;
   end
   assign tx_busy = (busyCnt != 0);

   task automatic checkOutput(input string tag, input logic [31:0] act, input logic [31:0] exp);
      testsRun++;
      if (act !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
      end
   endtask

   task automatic applyStimulus(input int req, input logic [7:0] data, input logic last);
      mem[req][tail[req]] = {last, data};
      tail[req]++;
   endtask

   task automatic clearLogs();
      nTx = 0;
      expN = 0;
      readyViol = 0;
      for (int i = 0; i < N; i++) begin
         head[i] = 0;
         tail[i] = 0;
      end
   endtask

   // Reference: whole packets go out in turn, next owner = first non-empty queue after the last owner.
   task automatic buildExpected(input int startOwner);
      int h [N];
      int owner;
      int pick;
      logic [8:0] e;
      for (int i = 0; i < N; i++) h[i] = head[i];
      owner = startOwner;
      forever begin
         pick = -1;
         for (int k = 1; k <= N; k++) begin
            if (pick < 0 && h[(owner + k) % N] < tail[(owner + k) % N]) pick = (owner + k) % N;
         end
         if (pick < 0) break;
         owner = pick;
         e = 9'h0;
         while (!e[8] && h[owner] < tail[owner]) begin
            e = mem[owner][h[owner]];
            h[owner]++;
            expData[expN] = e[7:0];
            expId[expN] = owner;
            expN++;
         end
      end
   endtask

   task automatic applyReset();
      @(negedge clk);
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #2;
   endtask

   task automatic waitTxCount(input int n, input int budget);
      int c = 0;
      while (nTx < n && c < budget) begin
         @(negedge clk); #2;
         c++;
      end
      checkOutput("wait_tx_count", nTx >= n, 1);
   endtask

   task automatic waitBusy(input logic val, input int budget);
      int c = 0;
      while (tx_busy !== val && c < budget) begin
         @(negedge clk); #2;
         c++;
      end
      checkOutput("wait_busy", tx_busy, val);
   endtask

   task automatic waitDone(input string tag, input int budget);
      int c = 0;
      while (!(nTx >= expN && !grant_valid && !tx_busy) && c < budget) begin
         @(negedge clk); #2;
         c++;
      end
      checkOutput({tag, "_byte_count"}, nTx, expN);
   endtask

   // Driver and monitor: present queue heads at negedge, then judge the settled cycle before posedge.
   initial begin
      logic [N-1:0] expReady;
      forever begin
         @(negedge clk);
         for (int i = 0; i < N; i++) begin
            if (head[i] < tail[i]) begin
               req_valid[i]       = 1'b1;
               req_data[8*i +: 8] = mem[i][head[i]][7:0];
               req_last[i]        = mem[i][head[i]][8];
            end else begin
               req_valid[i]       = 1'b0;
               req_data[8*i +: 8] = 8'($urandom);
               req_last[i]        = 1'($urandom);
            end
         end
         #1;
         if (!rst) begin
            cyc++;
            expReady = (grant_valid && !tx_busy) ? (N'(1) << grant_id) : '0;
            if ((req_ready & ~expReady) != '0) readyViol++;
            for (int i = 0; i < N; i++) begin
               if (req_valid[i] && req_ready[i]) head[i]++;
            end
            if (tx_valid) begin
               checkOutput("tx_busy_at_valid", tx_busy, 0);
               checkOutput("tx_valid_single", prevTxValid, 0);
               checkOutput("tx_spacing_ok", (cyc - lastTxCyc) >= FRAME + 2, 1);
               if (nTx < expN) begin
                  checkOutput($sformatf("tx_data[%0d]", nTx), tx_data, expData[nTx]);
                  checkOutput($sformatf("tx_owner[%0d]", nTx), grant_id, expId[nTx]);
               end else begin
                  checkOutput("extra_byte", nTx, expN);
               end
               nTx++;
               lastTxCyc = cyc;
            end
            prevTxValid = tx_valid;
         end
      end
   end

   initial begin
      int total, r, len, k;
      clearLogs();
      repeat (3) @(negedge clk);
      #2;
      checkOutput("rst_grant_id", grant_id, N - 1);
      checkOutput("rst_grant_valid", grant_valid, 0);
      checkOutput("rst_tx_valid", tx_valid, 0);
      checkOutput("rst_tx_data", tx_data, 0);
      checkOutput("rst_timeout", timeout_pulse, 0);
      checkOutput("rst_req_ready", req_ready, 0);
      rst = 1'b0;

      // Single two-byte packet from requester 0.
      applyStimulus(0, 8'h41, 1'b0);
      applyStimulus(0, 8'h42, 1'b1);
      buildExpected(N - 1);
      waitTxCount(2, 300);
      waitBusy(1'b1, 10);
      waitBusy(1'b0, 100);
      checkOutput("single_gv_hold", grant_valid, 1);
      checkOutput("single_gid", grant_id, 0);
      @(negedge clk); #2;
      checkOutput("single_gv_drop", grant_valid, 0);

      // Four one-byte packets pending together right after reset.
      applyReset();
      clearLogs();
      for (int i = 0; i < N; i++) applyStimulus(i, 8'h10 + 8'(i), 1'b1);
      buildExpected(N - 1);
      waitDone("rr", 800);

      // Requester 1 holds the lock across a 3-byte packet while requester 2 waits.
      applyReset();
      clearLogs();
      applyStimulus(1, 8'hB0, 1'b0);
      applyStimulus(1, 8'hB1, 1'b0);
      applyStimulus(1, 8'hB2, 1'b1);
      applyStimulus(2, 8'h20, 1'b1);
      buildExpected(N - 1);
      waitDone("lock", 800);
      checkOutput("lock_ready_rule", readyViol, 0);

      // Requester 3 goes quiet mid-packet and loses the lock after LT idle cycles.
      applyReset();
      clearLogs();
      applyStimulus(3, 8'h77, 1'b0);
      expData[0] = 8'h77; expId[0] = 3;
      expData[1] = 8'h55; expId[1] = 0;
      expN = 2;
      waitTxCount(1, 50);
      applyStimulus(0, 8'h55, 1'b1);
      waitBusy(1'b1, 10);
      waitBusy(1'b0, 100);
      k = 0;
      do begin
         @(negedge clk); #2;
         k++;
      end while (!timeout_pulse && k < 40);
      checkOutput("to_delay", k, LT + 1);
      checkOutput("to_grant_valid", grant_valid, 0);
      checkOutput("to_grant_id_kept", grant_id, 3);
      @(negedge clk); #2;
      checkOutput("to_pulse_width", timeout_pulse, 0);
      waitDone("timeout", 300);

      // Reset while the owner waits on tx_busy; the transmitter stays busy through it.
      applyReset();
      clearLogs();
      applyStimulus(2, 8'hA0, 1'b0);
      applyStimulus(2, 8'hA1, 1'b1);
      applyStimulus(3, 8'h33, 1'b1);
      buildExpected(N - 1);
      waitTxCount(1, 50);
      waitBusy(1'b1, 10);
      repeat (3) @(negedge clk);
      #2;
      rst = 1'b1;
      #1;
      checkOutput("mid_rst_grant_valid", grant_valid, 0);
      checkOutput("mid_rst_grant_id", grant_id, N - 1);
      checkOutput("mid_rst_tx_valid", tx_valid, 0);
      checkOutput("mid_rst_tx_data", tx_data, 0);
      checkOutput("mid_rst_req_ready", req_ready, 0);
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      #2;
      checkOutput("post_rst_busy", tx_busy, 1);
      checkOutput("post_rst_grant_valid", grant_valid, 1);
      checkOutput("post_rst_grant_id", grant_id, 2);
      checkOutput("post_rst_ready_held", req_ready, 0);
      waitDone("mid_rst", 400);

      // 64 random bytes in random-length packets from random requesters.
      applyReset();
      clearLogs();
      total = 0;
      while (total < 64) begin
         r = $urandom_range(0, N - 1);
         len = $urandom_range(1, 4);
         if (total + len > 64) len = 64 - total;
         for (int j = 0; j < len; j++) begin
            applyStimulus(r, 8'($urandom), j == len - 1);
            total++;
         end
      end
      buildExpected(N - 1);
      waitDone("random", 6000);
      checkOutput("random_ready_rule", readyViol, 0);

      $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
      $finish;
   end

endmodule
